// File: rtl/nios2e_debug_ocimem_pkg.sv
// Shared definitions for the Nios II on-chip debug memory controller:
// FSM states, JTAG op codes, jdo field positions and register offsets.
package nios2e_debug_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_J_RD,
        ST_J_WR,
        ST_C_RD
    } ocimem_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } jtag_op_t;

    localparam int JDO_RD_BIT   = 34;
    localparam int JDO_CLR_BIT  = 25;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_WD_MSB   = 34;
    localparam int JDO_WD_LSB   = 3;

    localparam int REG_STATUS_OFS = 0;

endpackage

// File: rtl/nios2e_debug_ocimem_ram.sv
// Single-port 2^AW x 32 synchronous RAM, byte enables, 1-cycle read.
// Ports: clk, addr, we, be, wdata in; rdata out (registered).
module nios2e_debug_ocimem_ram
    import nios2e_debug_ocimem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nios2e_debug_ocimem.sv
// Debug RAM controller: JTAG host reads/writes via jdo + take_action
// strobes, plus a CPU Avalon-MM slave onto the same RAM and a status
// register {monitor_error, monitor_ready}. JTAG always has priority.
// Ports: clk, reset_n, jdo, take_*_ocimem_*, debugack, avs_* slave,
// MonDReg, monitor_ready, monitor_error.
// Option macro OCIMEM_WPROT_EN: CPU RAM writes need debugack=1.
module nios2e_debug_ocimem
    import nios2e_debug_ocimem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_no_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          debugack,
    input  logic [AW:0]   avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    ocimem_state_t state_q, state_d;

    logic [AW-1:0] mon_a_reg;
    logic          slot_v;
    jtag_op_t      slot_op;
    logic [31:0]   slot_data;
    logic [31:0]   op_data;
    logic          rd_cap;
    logic          creg_sel_q;
    logic          creg_ofs0_q;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          any_strobe;
    logic          strobe_rd;
    logic          strobe_wr;
    logic          strobe_has_op;
    jtag_op_t      strobe_op;
    logic [31:0]   jdo_wdata;
    logic          jtag_go;
    jtag_op_t      go_op;
    logic [31:0]   go_data;
    logic          cpu_ok;
    logic          cpu_rd_go;
    logic          cpu_wr_go;
    logic          reg_sel;
    logic          reg_ofs0;
    logic          wprot_ok;
    logic          jtag_clr;
    logic          unused_ok;

    assign any_strobe = take_action_ocimem_a
                      | take_no_action_ocimem_a
                      | take_action_ocimem_b;

    assign strobe_rd = (take_action_ocimem_a & jdo[JDO_RD_BIT])
                     | take_no_action_ocimem_a;
    assign strobe_wr = take_action_ocimem_b;
    assign strobe_has_op = strobe_rd | strobe_wr;
    assign strobe_op = strobe_wr ? OP_WR : OP_RD;
    assign jdo_wdata = jdo[JDO_WD_MSB:JDO_WD_LSB];
    assign jtag_clr = take_action_ocimem_a & jdo[JDO_CLR_BIT];

    // A strobe arriving in IDLE with an empty slot starts at once;
    // otherwise the queued op runs and any new strobe is dropped.
    assign jtag_go = (state_q == ST_IDLE) & (slot_v | strobe_has_op);
    assign go_op   = slot_v ? slot_op : strobe_op;
    assign go_data = slot_v ? slot_data : jdo_wdata;

    assign cpu_ok    = (state_q == ST_IDLE) & ~slot_v & ~any_strobe;
    assign cpu_rd_go = cpu_ok & avs_read;
    assign cpu_wr_go = cpu_ok & avs_write & ~avs_read;
    assign reg_sel   = avs_address[AW];
    assign reg_ofs0  = (avs_address[AW-1:0] == AW'(REG_STATUS_OFS));

`ifdef OCIMEM_WPROT_EN
    assign wprot_ok  = debugack;
    assign unused_ok = ^{jdo[37:35], jdo[2:0]};
`else
    assign wprot_ok  = 1'b1;
    assign unused_ok = ^{jdo[37:35], jdo[2:0], debugack};
`endif

    // C_RD is the data phase of a CPU read, so it releases the stall.
    assign avs_waitrequest = (state_q == ST_J_RD)
                           | (state_q == ST_J_WR)
                           | slot_v
                           | any_strobe
                           | ((state_q == ST_IDLE) & avs_read);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (jtag_go) begin
                    state_d = (go_op == OP_WR) ? ST_J_WR : ST_J_RD;
                end else if (cpu_rd_go) begin
                    state_d = ST_C_RD;
                end
            end
            ST_J_RD: state_d = ST_IDLE;
            ST_J_WR: state_d = ST_IDLE;
            ST_C_RD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = mon_a_reg;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_wdata = op_data;
        if (state_q == ST_J_WR) begin
            ram_we = 1'b1;
        end else if ((cpu_rd_go | cpu_wr_go) & ~reg_sel) begin
            ram_addr  = avs_address[AW-1:0];
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
            ram_we    = cpu_wr_go & wprot_ok;
        end
    end

    always_comb begin
        avs_readdata = 32'h0;
        if (state_q == ST_C_RD) begin
            if (creg_sel_q) begin
                if (creg_ofs0_q) begin
                    avs_readdata = {30'h0, monitor_error, monitor_ready};
                end
            end else begin
                avs_readdata = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            slot_v      <= 1'b0;
            slot_op     <= OP_RD;
            slot_data   <= 32'h0;
            op_data     <= 32'h0;
            rd_cap      <= 1'b0;
            mon_a_reg   <= '0;
            MonDReg     <= 32'h0;
            creg_sel_q  <= 1'b0;
            creg_ofs0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_cap  <= (state_q == ST_J_RD);

            if (jtag_go) begin
                slot_v  <= 1'b0;
                op_data <= go_data;
            end else if (strobe_has_op && !slot_v) begin
                slot_v    <= 1'b1;
                slot_op   <= strobe_op;
                slot_data <= jdo_wdata;
            end

            // RAM output of the J_RD cycle is captured one cycle later.
            if (rd_cap) begin
                MonDReg <= ram_rdata;
            end

            if (take_action_ocimem_a) begin
                mon_a_reg <= jdo[AW+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
            end else if (rd_cap || state_q == ST_J_WR) begin
                mon_a_reg <= mon_a_reg + 1'b1;
            end

            if (cpu_rd_go) begin
                creg_sel_q  <= reg_sel;
                creg_ofs0_q <= reg_ofs0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else if (jtag_clr) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else if (cpu_wr_go && reg_sel && reg_ofs0 && avs_byteenable[0]) begin
            monitor_ready <= avs_writedata[0];
            monitor_error <= avs_writedata[1];
        end
    end

    nios2e_debug_ocimem_ram #(
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .be   (ram_be),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_nios2e_debug_ocimem.sv
// Self-checking bench for nios2e_debug_ocimem (AW=8): table-driven
// JTAG/CPU vectors plus hand-written latency and corner sequences.
module tb_nios2e_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0;
    logic        tn_a = 1'b0;
    logic        ta_b = 1'b0;
    logic        debugack = 1'b1;
    logic [8:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = 4'hF;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int total = 0;
    int bad = 0;

    nios2e_debug_ocimem #(.AW(8)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (ta_a),
        .take_no_action_ocimem_a(tn_a),
        .take_action_ocimem_b   (ta_b),
        .debugack               (debugack),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_byteenable         (avs_byteenable),
        .avs_readdata           (avs_readdata),
        .avs_waitrequest        (avs_waitrequest),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    // A strobe must never meet an occupied pending slot.
    always @(negedge clk) begin
        if (reset_n && dut.slot_v && (ta_a || tn_a || ta_b)) begin
            bad++;
            $display("FAIL slot_overrun: strobe while slot busy");
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    // kind 0: action_a (addr/rd/clr), 1: action_b (data), 2: no_action_a
    task automatic jpulse(input int kind, input logic [7:0] addr,
                          input bit rd, input bit clr,
                          input logic [31:0] data);
        jdo = '0;
        case (kind)
            0: begin
                jdo[24:17] = addr;
                jdo[34] = rd;
                jdo[25] = clr;
                ta_a = 1'b1;
            end
            1: begin
                jdo[34:3] = data;
                ta_b = 1'b1;
            end
            default: tn_a = 1'b1;
        endcase
        tick();
        ta_a = 1'b0;
        tn_a = 1'b0;
        ta_b = 1'b0;
    endtask

    task automatic cpu_wr(input logic [8:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        avs_address = addr;
        avs_writedata = data;
        avs_byteenable = be;
        avs_write = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                ok = 1'b1;
                cyc = i + 1;
                break;
            end
        end
        tick();
        avs_write = 1'b0;
        if (!ok) begin
            bad++;
            $display("FAIL cpu_wr_timeout: addr=%h", addr);
        end
    endtask

    task automatic cpu_rd(input logic [8:0] addr, output logic [31:0] data,
                          output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        data = 'x;
        avs_address = addr;
        avs_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                ok = 1'b1;
                cyc = i + 1;
                data = avs_readdata;
                break;
            end
        end
        tick();
        avs_read = 1'b0;
        if (!ok) begin
            bad++;
            $display("FAIL cpu_rd_timeout: addr=%h", addr);
        end
    endtask

    typedef struct {
        int          op;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int OP_JA  = 0;
    localparam int OP_JW  = 1;
    localparam int OP_JN  = 2;
    localparam int OP_CW  = 3;
    localparam int OP_CR  = 4;
    localparam int NV     = 18;

    initial begin
        vec_t        tbl [NV];
        logic [31:0] rd;
        int          cyc;
        int          lat;
        logic [31:0] cdata;

        tbl[0]  = '{OP_CW, 9'h000, 32'h0BADF00D, 4'hF, 0, 0, "w0"};
        tbl[1]  = '{OP_CW, 9'h011, 32'hA5A50011, 4'hF, 0, 0, "w11"};
        tbl[2]  = '{OP_JA, 9'h010, 32'h0, 4'hF, 0, 0, "ja10"};
        tbl[3]  = '{OP_JW, 9'h000, 32'hDEADBEEF, 4'hF, 0, 0, "jw10"};
        tbl[4]  = '{OP_JA, 9'h010, 32'h1, 4'hF, 1, 32'hDEADBEEF, "jrd_10"};
        tbl[5]  = '{OP_JN, 9'h000, 32'h0, 4'hF, 1, 32'hA5A50011, "jrd_11_inc"};
        tbl[6]  = '{OP_CR, 9'h010, 32'h0, 4'hF, 1, 32'hDEADBEEF, "crd_10"};
        tbl[7]  = '{OP_CR, 9'h000, 32'h0, 4'hF, 1, 32'h0BADF00D, "crd_00"};
        tbl[8]  = '{OP_CW, 9'h020, 32'hFFFFFFFF, 4'hF, 0, 0, "w20"};
        tbl[9]  = '{OP_CW, 9'h020, 32'h00000000, 4'h5, 0, 0, "w20be"};
        tbl[10] = '{OP_CR, 9'h020, 32'h0, 4'hF, 1, 32'hFF00FF00, "crd_byteen"};
        tbl[11] = '{OP_CR, 9'h100, 32'h0, 4'hF, 1, 32'h0, "reg_reset"};
        tbl[12] = '{OP_CW, 9'h100, 32'h3, 4'hF, 0, 0, "reg_w3"};
        tbl[13] = '{OP_CR, 9'h100, 32'h0, 4'hF, 1, 32'h3, "reg_rd3"};
        tbl[14] = '{OP_CW, 9'h101, 32'h0, 4'hF, 0, 0, "reg_w_ofs1"};
        tbl[15] = '{OP_CR, 9'h101, 32'h0, 4'hF, 1, 32'h0, "reg_ofs1"};
        tbl[16] = '{OP_CW, 9'h100, 32'h0, 4'h2, 0, 0, "reg_w_nobe0"};
        tbl[17] = '{OP_CR, 9'h100, 32'h0, 4'hF, 1, 32'h3, "reg_be0_ign"};

        // reset state
        settle(2);
        @(negedge clk);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", {31'h0, monitor_ready}, 32'h0);
        check("rst_error", {31'h0, monitor_error}, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_wait", {31'h0, avs_waitrequest}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            case (tbl[i].op)
                OP_JA: begin
                    jpulse(0, tbl[i].addr[7:0], tbl[i].data[0], 0, 0);
                    settle(6);
                    if (tbl[i].chk) check(tbl[i].name, MonDReg, tbl[i].exp);
                end
                OP_JW: begin
                    jpulse(1, 0, 0, 0, tbl[i].data);
                    settle(6);
                end
                OP_JN: begin
                    jpulse(2, 0, 0, 0, 0);
                    settle(6);
                    if (tbl[i].chk) check(tbl[i].name, MonDReg, tbl[i].exp);
                end
                OP_CW: begin
                    cpu_wr(tbl[i].addr, tbl[i].data, tbl[i].be, cyc);
                end
                default: begin
                    cpu_rd(tbl[i].addr, rd, cyc);
                    if (tbl[i].chk) check(tbl[i].name, rd, tbl[i].exp);
                end
            endcase
        end

        // CPU latencies
        cpu_wr(9'h030, 32'h00000030, 4'hF, cyc);
        check("cwr_latency", cyc, 1);
        cpu_rd(9'h030, rd, cyc);
        check("crd_latency", cyc, 2);
        check("crd_30", rd, 32'h00000030);

        // JTAG read latency: MonDReg changes exactly at N+3
        jpulse(0, 8'h10, 1, 0, 0);
        tick();
        @(negedge clk);
        check("jrd_lat_n2", MonDReg, 32'hA5A50011);
        tick();
        @(negedge clk);
        check("jrd_lat_n3", MonDReg, 32'hDEADBEEF);
        settle(3);

        // address wrap: write at 0xFF, following read hits 0x00
        jpulse(0, 8'hFF, 0, 0, 0);
        settle(5);
        jdo = '0;
        jdo[34:3] = 32'h00000001;
        ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
        tn_a = 1'b1;
        tick();
        tn_a = 1'b0;
        settle(8);
        check("wrap_rd0", MonDReg, 32'h0BADF00D);
        cpu_rd(9'h0FF, rd, cyc);
        check("wrap_wr_ff", rd, 32'h00000001);

        // CPU read contending with a JTAG write strobe
        jpulse(0, 8'h05, 0, 0, 0);
        settle(5);
        jdo = '0;
        jdo[34:3] = 32'hCAFE0005;
        ta_b = 1'b1;
        avs_address = 9'h005;
        avs_read = 1'b1;
        @(negedge clk);
        check("cont_wait_strobe", {31'h0, avs_waitrequest}, 32'h1);
        tick();
        ta_b = 1'b0;
        lat = 0;
        cdata = 32'h0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                lat = i;
                cdata = avs_readdata;
                break;
            end
        end
        tick();
        avs_read = 1'b0;
        check("cont_latency", lat, 3);
        check("cont_data", cdata, 32'hCAFE0005);

        // status set by CPU, cleared by JTAG
        @(negedge clk);
        check("stat_ready_set", {31'h0, monitor_ready}, 32'h1);
        check("stat_error_set", {31'h0, monitor_error}, 32'h1);
        tick();
        jpulse(0, 8'h00, 0, 1, 0);
        @(negedge clk);
        check("stat_ready_clr", {31'h0, monitor_ready}, 32'h0);
        check("stat_error_clr", {31'h0, monitor_error}, 32'h0);
        settle(4);

        // write protect option
        debugack = 1'b1;
        cpu_wr(9'h002, 32'h11111111, 4'hF, cyc);
        debugack = 1'b0;
        cpu_wr(9'h002, 32'h12345678, 4'hF, cyc);
        check("wprot_nostall", cyc, 1);
        cpu_rd(9'h002, rd, cyc);
`ifdef OCIMEM_WPROT_EN
        check("wprot_dropped", rd, 32'h11111111);
`else
        check("wprot_commit", rd, 32'h12345678);
`endif
        debugack = 1'b1;
        cpu_wr(9'h002, 32'h12345678, 4'hF, cyc);
        cpu_rd(9'h002, rd, cyc);
        check("wprot_ack_wr", rd, 32'h12345678);

        // reset in the middle of a JTAG read
        cpu_wr(9'h100, 32'h3, 4'hF, cyc);
        jpulse(0, 8'h10, 1, 0, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_mondreg", MonDReg, 32'h0);
        check("mid_rst_ready", {31'h0, monitor_ready}, 32'h0);
        check("mid_rst_error", {31'h0, monitor_error}, 32'h0);
        check("mid_rst_readdata", avs_readdata, 32'h0);
        check("mid_rst_wait", {31'h0, avs_waitrequest}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        cpu_rd(9'h010, rd, cyc);
        check("post_rst_lat", cyc, 2);
        check("post_rst_data", rd, 32'hDEADBEEF);
        jpulse(2, 0, 0, 0, 0);
        settle(6);
        check("post_rst_monareg0", MonDReg, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nios2e_debug_ocimem.md
# nios2e_debug_ocimem

On-chip debug memory controller for the Nios II debug module, directly downstream of the JTAG debug slave. It consumes `jdo` and the `take_action_ocimem_*` strobes to perform host reads and writes of a small debug RAM. It returns read data on `MonDReg` and exposes the `monitor_ready`/`monitor_error` handshake bits. It also arbitrates a CPU-side Avalon-MM slave port onto the same RAM and status register.

## Interface
Parameters:
- `AW`, 8 — RAM word-address width (2^AW x 32-bit words); legal range 1..8.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, the same clock as the debug slave's sysclk side.
- `reset_n`  in  1  asynchronous active-low reset.
- `jdo`  in  38  JTAG data-out word from the debug slave.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address, optional read, optional status clear.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: read at the current address.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write at the current address.
- `debugack`  in  1  CPU is in debug mode (used only with the write-protect option).
- `avs_address`  in  AW+1  CPU word address. Bit AW = 0 selects the RAM; bit AW = 1 selects the register region.
- `avs_read`  in  1  CPU read request.
- `avs_write`  in  1  CPU write request.
- `avs_writedata`  in  32  CPU write data.
- `avs_byteenable`  in  4  CPU byte enables.
- `avs_readdata`  out  32  CPU read data.
- `avs_waitrequest`  out  1  Avalon stall.
- `MonDReg`  out  32  last JTAG read result, returned to the debug slave.
- `monitor_ready`  out  1  status bit 0.
- `monitor_error`  out  1  status bit 1.

## Operation
- Internal state:
  - word address `MonAReg[AW-1:0]`;
  - one-deep JTAG pending slot holding an op (RD/WR) and the write data;
  - FSM with states IDLE, J_RD, J_WR, C_RD.
- `take_action_ocimem_a`:
  - `MonAReg <= jdo[AW+16:17]`.
  - If `jdo[34]`=1, a read is queued at the new address.
  - If `jdo[25]`=1, `monitor_ready` and `monitor_error` are cleared in the same cycle.
- `take_no_action_ocimem_a`: queues a read at the current `MonAReg`.
- `take_action_ocimem_b`: queues a write of `jdo[34:3]` with all byte enables set.
- Only one strobe can occur per cycle. A strobe that arrives while the slot is occupied is dropped; the bench asserts this never happens.
- FSM transitions:
  - IDLE with a pending read → J_RD; with a pending write → J_WR. The slot is cleared.
  - J_RD: the RAM is addressed. Next cycle `MonDReg` captures the RAM output, `MonAReg` increments, and the FSM returns to IDLE.
  - J_WR: the RAM is written, `MonAReg` increments, and the FSM returns to IDLE.
  - IDLE with no pending op and `avs_read` asserted → C_RD. C_RD → IDLE, presenting `avs_readdata`.
  - IDLE with no pending op and `avs_write` asserted: the write completes in that cycle.
- Address increments are modulo 2^AW: 2^AW-1 wraps to 0.
- Register region: only offset 0 is implemented.
  - Read returns {30'b0, `monitor_error`, `monitor_ready`}.
  - Write with `avs_byteenable[0]` loads both bits from `writedata[1:0]`.
  - Other offsets read as 0 and ignore writes.
  - Register reads also go through C_RD, giving uniform latency.
- Priority: the JTAG op is first. If a JTAG strobe (or pending op) and a CPU request occur in the same IDLE cycle, the CPU request stalls.
- Register write and JTAG clear (`jdo[25]`) in the same cycle: the clear wins.

## Timing
- Reset values: `MonDReg`=0, `MonAReg`=0, `monitor_ready`=0, `monitor_error`=0, FSM=IDLE, slot empty, `avs_readdata`=0.
- `avs_waitrequest` is combinational. It is high when any of the following holds:
  - FSM is not IDLE;
  - the slot is occupied;
  - a JTAG strobe is present;
  - `avs_read` is asserted in IDLE.
- With no request, `avs_waitrequest` is low, including during reset.
- JTAG read (strobe in cycle N): J_RD in N+1; `MonDReg` and the increment are visible from N+3.
- JTAG write (strobe in cycle N): J_WR in N+1; RAM content and `MonAReg` are updated from N+2.
- CPU read: 2 cycles when uncontended; `avs_readdata` is valid in the cycle `avs_waitrequest` falls.
- CPU write: 1 cycle when uncontended.
- Reset asserted mid-operation aborts at once. No partial write occurs, because a write occupies a single edge.

## Configuration
- `OCIMEM_WPROT_EN` defined: CPU RAM writes with `debugack`=0 are accepted (no stall) but discarded. Register writes and JTAG writes are unaffected.
- Not defined: `debugack` is ignored and CPU RAM writes always commit.

## Structure
- `nios2e_debug_ocimem_pkg` holds:
  - FSM state enum;
  - `jdo` field-position constants (read flag 34, clear flag 25, address LSB 17, write data 34:3);
  - register-region offset constants.
- Sub-module `nios2e_debug_ocimem_ram`: single-port 2^AW x 32 synchronous RAM with byte enables and 1-cycle read latency.

## Test plan
- `take_action_ocimem_a` with address 0x10 and `jdo[34]`=0, then `take_action_ocimem_b` with data 0xDEADBEEF; then `take_action_ocimem_a` with address 0x10 and `jdo[34]`=1 → `MonDReg`=0xDEADBEEF 3 cycles after the strobe, and `MonAReg`=0x11.
- Address 0xFF (AW=8), then JTAG write 0x1 followed by `take_no_action_ocimem_a` → write lands at 0xFF; the read returns the word at address 0x00 (wrap).
- CPU read of address 0x05 in the same cycle as a JTAG write strobe → `avs_waitrequest` stays high until the JTAG write completes; `avs_readdata` then shows the newly written value.
- CPU write of 0x3 to register offset 0 → `monitor_ready`=1 and `monitor_error`=1; `take_action_ocimem_a` with `jdo[25]`=1 → both bits are 0 in the next cycle.
- `OCIMEM_WPROT_EN` defined, `debugack`=0, CPU write of 0x12345678 to 0x02 → a subsequent read returns the old value; with `debugack`=1 the same write reads back 0x12345678.
- `reset_n` pulsed low during J_RD → all outputs return to their reset values; the FSM is IDLE and `MonDReg`=0.
